alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/alu_iter_core.sv | 68 ++++++
 rtl/alu_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    // True when an opcode needs the iterative datapath (DIV by zero short-circuits).
    function automatic logic needs_iter(input logic [OP_W-1:0] op, input logic b_zero);
        logic r;
        if (op == OP_MUL) begin
            r = 1'b1;
        end else if (op == OP_DIV) begin
            r = ~b_zero;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between a requester and the sequential ALU.
interface alu_seq_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [OP_W-1:0]  req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_div0;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_div0
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_div0
    );
endinterface

// File: rtl/alu_iter_core.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide.
// hi/lo hold {product high, product low} for MUL and {remainder, dividend/quotient}
// for DIV. The *_nxt_s outputs show the value the next step will register so the
// controller can capture the final result on the last iteration edge.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt_s,
    output logic [WIDTH-1:0] lo_nxt_s
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;

    // Next-step value for one multiplier bit or one quotient bit.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_r};
        if (div_mode) begin
            if (div_diff_s[WIDTH+1]) begin
                hi_nxt_s = div_shift_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_nxt_s = div_diff_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_nxt_s = mul_sum_s[WIDTH:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Operand latch on load, one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= a;
            b_r  <= b;
        end else if (step) begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
            b_r  <= b_r;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: handshake, FSM, iteration counter and result registers.
// ADD/SUB/DIV-by-zero complete in one cycle; MUL/DIV run WIDTH iterations in alu_iter_core.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus,
    output logic           busy
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             div0_r;

    logic             xfer_s;
    logic             b_zero_s;
    logic             load_s;
    logic             step_s;
    logic             div_mode_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] core_hi_s;
    logic [WIDTH-1:0] core_lo_s;

    assign bus.req_ready  = (state_r == IDLE);
    assign bus.rsp_valid  = (state_r == DONE);
    assign busy           = (state_r != IDLE);
    assign bus.rsp_result = result_r;
    assign bus.rsp_carry  = carry_r;
    assign bus.rsp_div0   = div0_r;

    // Handshake decode and single-cycle arithmetic on the live request.
    always_comb begin
        xfer_s     = bus.req_valid && (state_r == IDLE);
        b_zero_s   = (bus.req_b == {WIDTH{1'b0}});
        load_s     = xfer_s && needs_iter(bus.req_op, b_zero_s);
        step_s     = (state_r == MUL) || (state_r == DIV);
        div_mode_s = (state_r == DIV);
        add_s      = {1'b0, bus.req_a} + {1'b0, bus.req_b};
        sub_s      = {1'b0, bus.req_a} - {1'b0, bus.req_b};
    end

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step     (step_s),
        .div_mode (div_mode_s),
        .a        (bus.req_a),
        .b        (bus.req_b),
        .hi_nxt_s (core_hi_s),
        .lo_nxt_s (core_lo_s)
    );

    // Control FSM with iteration counter and registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        case (bus.req_op)
                            OP_MUL: begin
                                state_r <= MUL;
                                cnt_r   <= CNT_LOAD;
                            end
                            OP_DIV: begin
                                if (b_zero_s) begin
                                    state_r  <= DONE;
                                    result_r <= {WIDTH{1'b1}};
                                    carry_r  <= 1'b0;
                                    div0_r   <= 1'b1;
                                end else begin
                                    state_r <= DIV;
                                    cnt_r   <= CNT_LOAD;
                                end
                            end
                            OP_SUB: begin
                                state_r  <= DONE;
                                result_r <= sub_s[WIDTH-1:0];
                                carry_r  <= sub_s[WIDTH];
                                div0_r   <= 1'b0;
                            end
                            default: begin
                                state_r  <= DONE;
                                result_r <= add_s[WIDTH-1:0];
                                carry_r  <= add_s[WIDTH];
                                div0_r   <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r  <= DONE;
                        result_r <= core_lo_s;
                        carry_r  <= |core_hi_s;
                        div0_r   <= 1'b0;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DIV: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r  <= DONE;
                        result_r <= core_lo_s;
                        carry_r  <= 1'b0;
                        div0_r   <= 1'b0;
                    end else begin
                        state_r <= DIV;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, a reset-abort
// sequence and randomized operations checked against an arithmetic model.
module tb_alu_seq_ctrl;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    logic busy;

    int checks;
    int errors;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] exp_res;
        logic        exp_carry;
        logic        exp_div0;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer maths on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic d,
                                  output int lat);
        logic [63:0] p;
        d = 1'b0;
        case (op)
            4'd1: begin
                r = a - b; c = (a < b); lat = 1;
            end
            4'd2: begin
                p = 64'(a) * 64'(b);
                r = p[31:0]; c = (p[63:32] != 64'd0); lat = W + 1;
            end
            4'd3: begin
                c = 1'b0;
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF; d = 1'b1; lat = 1;
                end else begin
                    r = a / b; lat = W + 1;
                end
            end
            default: begin
                p = 64'(a) + 64'(b);
                r = p[31:0]; c = p[32]; lat = 1;
            end
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete transaction: transfer, latency measurement, optional back-pressure, release.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic [31:0] er, input logic ec,
                          input logic ed, input int elat, input string tag);
        int          lat;
        int          waitc;
        logic        ready_low_ok;
        logic        stable_ok;
        logic [31:0] r0;
        logic        c0;
        logic        d0;

        @(negedge clk);
        waitc = 0;
        while (!bus.req_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        bus.rsp_ready = (hold == 0);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom_range(0, 15));
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;

        lat = 0;
        ready_low_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.rsp_valid && (bus.req_ready || !busy)) ready_low_ok = 1'b0;
        end while (!bus.rsp_valid && lat < 100);

        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " result"}, 64'(bus.rsp_result), 64'(er));
        check({tag, " carry"}, 64'(bus.rsp_carry), 64'(ec));
        check({tag, " div0"}, 64'(bus.rsp_div0), 64'(ed));
        check({tag, " ready low while working"}, 64'(ready_low_ok), 64'd1);

        if (!bus.rsp_valid) begin
            do_reset();
        end else begin
            if (hold > 0) begin
                r0 = bus.rsp_result; c0 = bus.rsp_carry; d0 = bus.rsp_div0;
                stable_ok = 1'b1;
                repeat (hold) begin
                    @(negedge clk);
                    if (bus.rsp_result !== r0 || bus.rsp_carry !== c0 || bus.rsp_div0 !== d0 ||
                        !bus.rsp_valid || bus.req_ready)
                        stable_ok = 1'b0;
                end
                check({tag, " held stable"}, 64'(stable_ok), 64'd1);
                bus.rsp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            check({tag, " idle after accept"}, {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
            bus.rsp_ready = 1'b0;
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] mr;
        logic        mc;
        logic        md;
        int          ml;
        logic        abort_ok;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        checks = 0;
        errors = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;

        vecs[0]  = '{4'h0, 32'hFFFF_FFFF, 32'd1,          0,  32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[1]  = '{4'h1, 32'd3,         32'd5,          0,  32'hFFFF_FFFE, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'h2, 32'h0001_0000, 32'h0001_0000,  0,  32'h0000_0000, 1'b1, 1'b0, 33};
        vecs[3]  = '{4'h3, 32'd100,       32'd7,          0,  32'd14,        1'b0, 1'b0, 33};
        vecs[4]  = '{4'h3, 32'd5,         32'd0,          0,  32'hFFFF_FFFF, 1'b0, 1'b1, 1};
        vecs[5]  = '{4'h2, 32'd6,         32'd7,          10, 32'd42,        1'b0, 1'b0, 33};
        vecs[6]  = '{4'hF, 32'd1,         32'd2,          0,  32'd3,         1'b0, 1'b0, 1};
        vecs[7]  = '{4'h1, 32'd5,         32'd3,          2,  32'd2,         1'b0, 1'b0, 1};
        vecs[8]  = '{4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0,  32'h0000_0001, 1'b1, 1'b0, 33};
        vecs[9]  = '{4'h3, 32'hFFFF_FFFF, 32'd1,          1,  32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[10] = '{4'h3, 32'd7,         32'd100,        0,  32'd0,         1'b0, 1'b0, 33};
        vecs[11] = '{4'h0, 32'd0,         32'd0,          0,  32'd0,         1'b0, 1'b0, 1};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", 64'(bus.rsp_result), 64'd0);
        check("reset flags", {62'd0, bus.rsp_carry, bus.rsp_div0}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after release", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_res,
                   vecs[i].exp_carry, vecs[i].exp_div0, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset asserted part-way through a DIV aborts it with no response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'h3;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort result", 64'(bus.rsp_result), 64'd0);
        check("abort flags", {62'd0, bus.rsp_carry, bus.rsp_div0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        abort_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid || busy || !bus.req_ready) abort_ok = 1'b0;
        end
        check("abort no response", 64'(abort_ok), 64'd1);
        run_op(4'h0, 32'd2, 32'd2, 0, 32'd4, 1'b0, 1'b0, 1, "post-abort add");

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 5));
            if (rop > 4'd3) rop = 4'($urandom_range(4, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            model(rop, ra, rb, mr, mc, md, ml);
            run_op(rop, ra, rb, $urandom_range(0, 3), mr, mc, md, ml, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
